// File: rtl/fetch_if.sv
// Handshake bundle between the fetch unit, instruction memory, the decoder and
// the redirect source. master = fetch unit side, slave = environment side.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misaligned;

  modport master (
    output imem_req, imem_addr, instruction, inst_valid, pc, pc_plus4, misaligned,
    input  imem_rvalid, imem_rdata, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instruction, inst_valid, pc, pc_plus4, misaligned,
    output imem_rvalid, imem_rdata, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding imem read at a
// time and presents a registered instruction/pc slot (plus a 1-entry skid) to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  typedef enum logic [2:0] {IDLE, FETCH, STALLED, DRAIN, HALT} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] target_pc;
  logic        req_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        skid_valid;
  logic        misaligned_q;

  logic consume;
  logic slot_free;

  assign consume   = valid_q & ~bus.stall;
  assign slot_free = ~valid_q | ~bus.stall;

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = fetch_pc;
  assign bus.instruction = instr_q;
  assign bus.inst_valid  = valid_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + 32'd4;
  assign bus.misaligned  = misaligned_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      fetch_pc     <= RESET_PC;
      target_pc    <= RESET_PC;
      req_q        <= 1'b0;
      instr_q      <= NOP_INSTR;
      pc_q         <= RESET_PC;
      valid_q      <= 1'b0;
      // NOTE: the skid payload is reset too; it is only a few flops and keeps X out of the slot.
      skid_instr   <= NOP_INSTR;
      skid_pc      <= RESET_PC;
      skid_valid   <= 1'b0;
      misaligned_q <= 1'b0;
    end else if (bus.redirect_valid && state != HALT) begin
      // Redirect outranks stall and rvalid: flush slot and skid in every case.
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      skid_valid <= 1'b0;
      if (bus.redirect_pc[1:0] != 2'b00) begin
        misaligned_q <= 1'b1;
        req_q        <= 1'b0;
        state        <= HALT;
      end else if ((state == FETCH || state == DRAIN) && !bus.imem_rvalid) begin
        // Request still in flight: keep it on the bus, retire it, then jump.
        target_pc <= bus.redirect_pc;
        req_q     <= 1'b1;
        state     <= DRAIN;
      end else begin
        fetch_pc <= bus.redirect_pc;
        req_q    <= 1'b1;
        state    <= FETCH;
      end
    end else begin
      case (state)
        IDLE: begin
          req_q <= 1'b1;
          state <= FETCH;
        end
        FETCH: begin
          if (bus.imem_rvalid) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (slot_free) begin
              instr_q <= bus.imem_rdata;
              pc_q    <= fetch_pc;
              valid_q <= 1'b1;
            end else begin
              skid_instr <= bus.imem_rdata;
              skid_pc    <= fetch_pc;
              skid_valid <= 1'b1;
              req_q      <= 1'b0;
              state      <= STALLED;
            end
          end else if (consume) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
          end
        end
        STALLED: begin
          if (consume) begin
            instr_q    <= skid_instr;
            pc_q       <= skid_pc;
            valid_q    <= skid_valid;
            skid_valid <= 1'b0;
            req_q      <= 1'b1;
            state      <= FETCH;
          end
        end
        DRAIN: begin
          if (consume) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
          end
          if (bus.imem_rvalid) begin
            fetch_pc <= target_pc;
            state    <= FETCH;
          end
        end
        HALT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          instr_q <= NOP_INSTR;
        end
        default: begin
          req_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the instruction decoder. Holds the program counter and issues one-outstanding-request reads to instruction memory. Presents a registered 32-bit instruction plus its PC to the decoder with a valid/stall handshake. Applies branch/jump redirects from control/execute and discards wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
NOP_INSTR, 32'h0000_0013, value driven on instruction when no valid instruction is held (addi x0,x0,0).

Ports:
clk  input  1  system clock, all state on rising edge.
rst  input  1  asynchronous reset, active-high.
imem_req  output  1  instruction memory read request.
imem_addr  output  32  word-aligned read address.
imem_rvalid  input  1  read data valid; one response per request, arrives ≥1 cycle after the request is first asserted.
imem_rdata  input  32  read data, sampled when imem_rvalid=1.
stall  input  1  decoder/control cannot accept the presented instruction this cycle.
redirect_valid  input  1  one-cycle pulse: change fetch flow.
redirect_pc  input  32  new fetch address.
instruction  output  32  instruction to the decoder.
inst_valid  output  1  instruction/pc hold a valid fetched instruction.
pc  output  32  address of the presented instruction.
pc_plus4  output  32  pc + 4, modulo 2^32.
misaligned  output  1  sticky flag: redirect_pc[1:0] != 0 was received.

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. Reset values: fetch_pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, instruction=NOP_INSTR, inst_valid=0, pc=RESET_PC, pc_plus4=RESET_PC+4, misaligned=0, skid buffer empty. Reset mid-transaction abandons the outstanding request; a late imem_rvalid after reset release is ignored unless in FETCH/DRAIN.
- Output slot: a registered instruction/pc pair, plus a 1-entry skid register. Consume = inst_valid & ~stall.
- imem_addr = fetch_pc at all times. fetch_pc[1:0] is always 2'b00.
- States:
  - IDLE: imem_req=0. Go to FETCH the cycle after reset release.
  - FETCH: imem_req=1, held high until imem_rvalid (never withdrawn).
    - On rvalid with the slot empty or consumed this cycle: load the slot (instruction=imem_rdata, pc=fetch_pc) and set fetch_pc+=4. If the skid buffer is empty, stay in FETCH; the next request is issued the following cycle.
    - On rvalid with the slot full and stall=1: write the data to the skid buffer, set fetch_pc+=4, and go to STALLED.
  - STALLED: imem_req=0. When the slot is consumed, move skid to slot and go to FETCH.
  - DRAIN: entered on redirect while a request is outstanding (FETCH without rvalid that cycle). imem_req stays 1 with imem_addr = the old address until rvalid. That data is discarded, then go to FETCH with fetch_pc = the latched redirect target.
  - HALT: imem_req=0, inst_valid=0. Left only by rst.
- Latency: imem_rvalid in cycle N gives instruction/inst_valid visible in cycle N+1. Peak throughput is 1 instruction per 2 cycles with single-cycle memory.
- When the slot is consumed and nothing is loaded in the same cycle, inst_valid goes to 0 and instruction goes to NOP_INSTR.
- Redirect (priority over stall and rvalid):
  - Clears the slot and the skid buffer (inst_valid=0 next cycle) and loads fetch_pc = redirect_pc.
  - rvalid in the same cycle as redirect: the data is dropped; next state is FETCH (no drain needed).
  - Redirect in IDLE or STALLED: next state is FETCH.
  - Redirect during DRAIN: only the latched target is updated.
  - redirect_pc[1:0] != 0: misaligned=1 and next state is HALT. The slot and skid buffer are cleared.
- pc_plus4 is combinational from pc and wraps 32'hFFFF_FFFC to 32'h0000_0000. fetch_pc wraps likewise.

Test Plan:
- Reset release, memory returns rdata one cycle after req, no stall -> imem_addr sequence 0x0,0x4,0x8. Instructions appear with pc=0x0,0x4,0x8 and inst_valid pulses every other cycle.
- Slot full, stall=1, rvalid arrives with 0x00500093 -> data goes to skid, imem_req=0. Release stall -> next cycle instruction=0x00500093, then req resumes at the next address.
- Redirect to 0x100 while a request to 0x20 is outstanding (rvalid 3 cycles later) -> req held at 0x20 until rvalid, data dropped, next req at 0x100, and no 0x20 instruction is ever valid.
- Redirect to 0x40 in the same cycle as rvalid -> data dropped, inst_valid=0, next imem_addr=0x40.
- Redirect to 0x102 -> misaligned=1, imem_req=0 permanently, inst_valid=0. Asserting rst clears misaligned and fetch restarts at RESET_PC.
- Redirect to 0xFFFF_FFFC -> pc=0xFFFF_FFFC with pc_plus4=0x0. The next imem_addr=0x0.
